// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and limits for the LC3 memory responder.
package lc3_mem_pkg;
   localparam int WORD_W  = 16;
   localparam int CNT_W   = 4;
   localparam int LAT_MAX = 15;
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/lc3_mem_responder_if.sv
// lc3_mem_responder_if: fetch, data and preload signals between core/bench and responder.
interface lc3_mem_responder_if
   import lc3_mem_pkg::*;
#(parameter int ADDR_W = 8);
   logic [WORD_W-1:0] pc;
   logic              instrmem_rd;
   logic [WORD_W-1:0] Instr_dout;
   logic              complete_instr;
   logic              Data_req;
   logic              Data_rd;
   logic [WORD_W-1:0] Data_addr;
   logic [WORD_W-1:0] Data_din;
   logic [WORD_W-1:0] Data_dout;
   logic              complete_data;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [WORD_W-1:0] load_data;
   modport master (
      output pc, instrmem_rd, Data_req, Data_rd, Data_addr, Data_din, load_en, load_addr, load_data,
      input  Instr_dout, complete_instr, Data_dout, complete_data
   );
   modport slave (
      input  pc, instrmem_rd, Data_req, Data_rd, Data_addr, Data_din, load_en, load_addr, load_data,
      output Instr_dout, complete_instr, Data_dout, complete_data
   );
endinterface

// File: rtl/lc3_mem_port_fsm.sv
// lc3_mem_port_fsm: per-port IDLE/BUSY sequencer; latches a request payload,
// counts LAT wait cycles, flags the commit edge and registers the completion pulse.
module lc3_mem_port_fsm
   import lc3_mem_pkg::*;
#(
   parameter int LAT = 0,
   parameter int P_W = 8
)(
   input  logic           clock,
   input  logic           reset,
   input  logic           i_req,
   input  logic [P_W-1:0] i_payload,
   output logic           o_fire,
   output logic [P_W-1:0] o_payload,
   output logic           o_complete
);
   localparam logic [0:0] IDLE = ST_IDLE;
   localparam logic [0:0] BUSY = ST_BUSY;

   if (LAT < 0 || LAT > LAT_MAX) begin : g_lat_chk
      $error("lc3_mem_port_fsm: LAT out of range 0..15");
   end

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [P_W-1:0]   r_payload;
   logic             r_complete;

   assign o_fire     = (r_state == BUSY) && (r_cnt == '0);
   assign o_payload  = r_payload;
   assign o_complete = r_complete;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_payload  <= '0;
         r_complete <= 1'b0;
      end else begin
         r_complete <= o_fire;
         if (r_state == IDLE) begin
            if (i_req) begin
               r_payload <= i_payload;
               r_cnt     <= CNT_W'(LAT);
               r_state   <= BUSY;
            end
         end else if (o_fire) begin
            r_state <= IDLE;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: unified word array answering LC3 fetch and data ports
// concurrently, with a preload write port for program loading.
module lc3_mem_responder
   import lc3_mem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int INSTR_LAT = 0,
   parameter int DATA_LAT  = 1
)(
   input logic                 clock,
   input logic                 reset,
   lc3_mem_responder_if.slave  bus
);
   localparam int D_W = 1 + WORD_W + ADDR_W;

   logic              w_i_fire;
   logic [ADDR_W-1:0] w_i_addr;
   logic              w_d_fire;
   logic [D_W-1:0]    w_d_payload;
   logic              w_d_rd;
   logic [WORD_W-1:0] w_d_din;
   logic [ADDR_W-1:0] w_d_addr;
   logic [WORD_W-1:0] r_mem [2**ADDR_W];
   logic [WORD_W-1:0] r_instr;
   logic [WORD_W-1:0] r_data;

   assign {w_d_rd, w_d_din, w_d_addr} = w_d_payload;
   assign bus.Instr_dout = r_instr;
   assign bus.Data_dout  = r_data;

   lc3_mem_port_fsm #(.LAT(INSTR_LAT), .P_W(ADDR_W)) u_instr (
      .clock      (clock),
      .reset      (reset),
      .i_req      (bus.instrmem_rd),
      .i_payload  (bus.pc[ADDR_W-1:0]),
      .o_fire     (w_i_fire),
      .o_payload  (w_i_addr),
      .o_complete (bus.complete_instr)
   );

   lc3_mem_port_fsm #(.LAT(DATA_LAT), .P_W(D_W)) u_data (
      .clock      (clock),
      .reset      (reset),
      .i_req      (bus.Data_req),
      .i_payload  ({bus.Data_rd, bus.Data_din, bus.Data_addr[ADDR_W-1:0]}),
      .o_fire     (w_d_fire),
      .o_payload  (w_d_payload),
      .o_complete (bus.complete_data)
   );

   // Data-port commit is ordered after the preload so it wins on an address clash.
   always_ff @(posedge clock) begin
      if (bus.load_en) r_mem[bus.load_addr] <= bus.load_data;
      if (w_d_fire && !w_d_rd) r_mem[w_d_addr] <= w_d_din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_instr <= '0;
         r_data  <= '0;
      end else begin
         if (w_i_fire) r_instr <= r_mem[w_i_addr];
         if (w_d_fire && w_d_rd) r_data <= r_mem[w_d_addr];
      end
   end
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed stimulus with queued expectations checked by a monitor.
module tb_lc3_mem_responder;
   localparam int INSTR_LAT = 0;
   localparam int DATA_LAT  = 3;

   typedef struct {logic [15:0] v; int c;} exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_d = 16'h0;
   logic prev_ci = 1'b0;
   logic prev_cd = 1'b0;
   exp_t iq[$];
   exp_t dq[$];

   lc3_mem_responder_if #(.ADDR_W(8)) bus ();

   lc3_mem_responder #(.ADDR_W(8), .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (bus.complete_instr) begin
         chk("instr_pulse_width", {31'd0, prev_ci}, 32'd0);
         if (iq.size() == 0) chk("instr_unexpected", 32'd1, 32'd0);
         else begin
            e = iq.pop_front();
            chk("instr_data", {16'd0, bus.Instr_dout}, {16'd0, e.v});
            chk("instr_cycle", cyc, e.c);
         end
      end
      if (bus.complete_data) begin
         chk("data_pulse_width", {31'd0, prev_cd}, 32'd0);
         if (dq.size() == 0) chk("data_unexpected", 32'd1, 32'd0);
         else begin
            e = dq.pop_front();
            chk("data_dout", {16'd0, bus.Data_dout}, {16'd0, e.v});
            chk("data_cycle", cyc, e.c);
         end
      end
      prev_ci = bus.complete_instr;
      prev_cd = bus.complete_data;
   end

   task automatic i_req(input logic [15:0] a, input logic [15:0] v);
      bus.instrmem_rd = 1'b1;
      bus.pc = a;
      iq.push_back('{v, cyc + 2 + INSTR_LAT});
   endtask

   task automatic d_req(input logic rd, input logic [15:0] a, input logic [15:0] din,
                        input logic [15:0] rv, input bit track);
      bus.Data_req = 1'b1;
      bus.Data_rd = rd;
      bus.Data_addr = a;
      bus.Data_din = din;
      if (track) begin
         if (rd) exp_d = rv;
         dq.push_back('{exp_d, cyc + 2 + DATA_LAT});
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] v);
      @(negedge clock);
      bus.load_en = 1'b1;
      bus.load_addr = a;
      bus.load_data = v;
      @(negedge clock);
      bus.load_en = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] a, input logic [15:0] v);
      @(negedge clock);
      i_req(a, v);
      @(negedge clock);
      bus.instrmem_rd = 1'b0;
      repeat (INSTR_LAT + 2) @(negedge clock);
   endtask

   task automatic data_op(input logic rd, input logic [15:0] a, input logic [15:0] din,
                          input logic [15:0] rv);
      @(negedge clock);
      d_req(rd, a, din, rv, 1'b1);
      @(negedge clock);
      bus.Data_req = 1'b0;
      bus.Data_addr = 16'h00FF;
      repeat (DATA_LAT + 2) @(negedge clock);
   endtask

   initial begin
      bus.pc = 16'h0; bus.instrmem_rd = 1'b0;
      bus.Data_req = 1'b0; bus.Data_rd = 1'b0; bus.Data_addr = 16'h0; bus.Data_din = 16'h0;
      bus.load_en = 1'b0; bus.load_addr = 8'h0; bus.load_data = 16'h0;
      repeat (3) @(negedge clock);
      chk("rst_instr_dout", {16'd0, bus.Instr_dout}, 32'd0);
      chk("rst_data_dout", {16'd0, bus.Data_dout}, 32'd0);
      chk("rst_complete", {30'd0, bus.complete_instr, bus.complete_data}, 32'd0);
      reset = 1'b0;
      load(8'h10, 16'h1234);
      for (int i = 0; i < 4; i++) load(8'(i), 16'hA000 + 16'(i));
      load(8'h30, 16'h0303);
      load(8'h40, 16'h4040);
      fetch(16'h0010, 16'h1234);
      data_op(1'b0, 16'h0020, 16'hBEEF, 16'h0);
      data_op(1'b1, 16'h0020, 16'h0, 16'hBEEF);
      repeat (4) @(negedge clock);
      chk("data_dout_hold", {16'd0, bus.Data_dout}, 32'h0000BEEF);
      data_op(1'b0, 16'h0105, 16'hAAAA, 16'h0);
      fetch(16'h0005, 16'hAAAA);
      // Write commit, load to same address and fetch of it all land on one edge.
      @(negedge clock);
      d_req(1'b0, 16'h0030, 16'h5555, 16'h0, 1'b1);
      @(negedge clock);
      bus.Data_req = 1'b0;
      @(negedge clock);
      @(negedge clock);
      i_req(16'h0030, 16'h0303);
      @(negedge clock);
      bus.instrmem_rd = 1'b0;
      bus.load_en = 1'b1; bus.load_addr = 8'h30; bus.load_data = 16'h7777;
      @(negedge clock);
      bus.load_en = 1'b0;
      repeat (3) @(negedge clock);
      data_op(1'b1, 16'h0030, 16'h0, 16'h5555);
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clock);
         i_req(16'(i), 16'hA000 + 16'(i));
         @(negedge clock);
         bus.pc = 16'h0010;
      end
      @(negedge clock);
      bus.instrmem_rd = 1'b0;
      repeat (4) @(negedge clock);
      @(negedge clock);
      d_req(1'b0, 16'h0040, 16'h9999, 16'h0, 1'b0);
      @(negedge clock);
      bus.Data_req = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_data_dout", {16'd0, bus.Data_dout}, 32'd0);
      chk("async_rst_instr_dout", {16'd0, bus.Instr_dout}, 32'd0);
      chk("async_rst_complete", {30'd0, bus.complete_instr, bus.complete_data}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_d = 16'h0;
      repeat (6) @(negedge clock);
      data_op(1'b1, 16'h0040, 16'h0, 16'h4040);
      repeat (6) @(negedge clock);
      chk("instr_queue_drained", iq.size(), 32'd0);
      chk("data_queue_drained", dq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
Synthesizable memory-side responder for the LC3 core.
- Answers instruction fetches (pc, instrmem_rd) with Instr_dout / complete_instr.
- Answers data reads and writes (Data_addr, Data_din, Data_rd) with Data_dout / complete_data.
- Holds one unified word array. A preload port lets the bench load programs without driving per-cycle stimulus.
- Sits opposite the core's fetch and memaccess stages, taking the place of the bench-driven memory.

Parameters:
ADDR_W, 8, word-address bits actually decoded; array depth is 2**ADDR_W 16-bit words.
INSTR_LAT, 0, extra wait cycles before an instruction response (0..15).
DATA_LAT, 1, extra wait cycles before a data response (0..15).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
pc  input  16  fetch address; only bits [ADDR_W-1:0] are used.
instrmem_rd  input  1  fetch request, sampled in IDLE.
Instr_dout  output  16  fetched instruction word.
complete_instr  output  1  one-cycle pulse; Instr_dout is valid this cycle.
Data_req  input  1  data access request, sampled in IDLE.
Data_rd  input  1  1 = read, 0 = write; sampled with Data_req.
Data_addr  input  16  data address; only bits [ADDR_W-1:0] are used.
Data_din  input  16  write data; sampled with Data_req.
Data_dout  output  16  read data.
complete_data  output  1  one-cycle pulse; read data valid or write committed.
load_en  input  1  preload write strobe.
load_addr  input  ADDR_W  preload address.
load_data  input  16  preload data.

Behaviour:
- Reset: both FSMs go to IDLE; Instr_dout=0, Data_dout=0, complete_instr=0, complete_data=0; counters=0. Array contents are not cleared.
- Reset mid-access aborts the access: no completion pulse and no write commit.
- Two independent FSMs, one per port, each with states IDLE and BUSY.
- IDLE: at a rising edge with the port's request high:
  - latch the address (plus Data_rd and Data_din for the data port);
  - load the counter with the port's LAT;
  - go to BUSY.
- BUSY, counter != 0: decrement the counter.
- BUSY, counter == 0, same edge:
  - instruction port: Instr_dout <= mem[latched addr]; complete_instr <= 1; go to IDLE.
  - data read: Data_dout <= mem[latched addr]; complete_data <= 1; go to IDLE.
  - data write: mem[latched addr] <= latched Din; Data_dout unchanged; complete_data <= 1; go to IDLE.
- Timing: request sampled at edge k gives a completion pulse visible in the cycle after edge k+1+LAT.
- Throughput: one access per 2+LAT cycles per port. The IDLE cycle that shows the pulse samples the next request at its closing edge.
- Completion pulses are registered and last exactly one cycle. Outputs hold their last value between completions.
- Requests are latched: dropping a request or changing the address while BUSY has no effect. Inputs are ignored in BUSY.
- Addresses alias modulo 2**ADDR_W; upper bits are ignored.
- The two ports operate concurrently; both may complete on the same edge.
- Same-edge collisions:
  - instruction read of the address being written returns the old data (read-before-write);
  - data read colliding with a load write also returns the old data;
  - data-write commit and load_en to the same address: the data-port value wins;
  - load_en to a different address: both writes take effect.
- load_en writes the array at any edge, independent of FSM state, with no completion pulse.
- Counter width is 4 bits. LAT > 15 fails an elaboration-time check.

Decomposition:
- Shared package lc3_mem_pkg: state enum (IDLE, BUSY), LAT_MAX=15, word width constant 16.
- Sub-module lc3_mem_port_fsm (parameter LAT): request latch, counter and completion pulse. Instantiated twice.
- Array, write arbitration and read muxing stay in the top.

Test Plan:
- Preload via load_en: mem[0x10]=0x1234. Assert pc=0x0010, instrmem_rd=1 for one cycle with INSTR_LAT=0 -> complete_instr pulses in the cycle after the next edge, with Instr_dout=0x1234; pulse width exactly 1.
- DATA_LAT=3: write Data_addr=0x0020, Din=0xBEEF, Data_rd=0 -> complete_data after 5 edges. Then a read of 0x0020 returns Data_dout=0xBEEF after another 5 edges, and Data_dout stays 0xBEEF afterwards.
- Aliasing with ADDR_W=8: write 0xAAAA to 0x0105, then fetch pc=0x0005 -> Instr_dout=0xAAAA.
- Same-edge collision: data-write commit of 0x5555 to 0x30 with load_en writing 0x7777 to 0x30 -> mem[0x30]=0x5555. Simultaneous fetch of 0x30 returns the pre-write value.
- Reset asserted asynchronously while the data port is BUSY with a write to 0x40 -> outputs 0 immediately, no complete_data, mem[0x40] unchanged.
- Back-to-back with instrmem_rd held high and INSTR_LAT=0 over pc 0..3 -> one complete_instr every 2 cycles, returning the preloaded words in order.
